// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (common with the ALU controller),
// execute-unit FSM states and small decode helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLT = 4'b1001,
    OP_LUI = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // True for the three shift operations.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the execute unit.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds valid and its payload stable until that edge;
// ready may depend on state only, never on valid of the same channel.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_taken;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_taken, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_taken, out_illegal
  );
endinterface

// File: rtl/alu_comb_core.sv
// Combinational ALU core: all non-shift ops, plus the shift ops.
// Macro BARREL_SHIFT_EN: when defined, shifts are done here by a barrel
// shifter; otherwise shift ops pass operand A through (used only for a
// shift amount of zero, the serial path in the top does the rest).
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             taken,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

`ifdef BARREL_SHIFT_EN
  logic [SW-1:0]           shamt;
  logic signed [WIDTH-1:0] a_s;
  assign shamt = b[SW-1:0];
  assign a_s   = a;
`endif

  // Decode the op code and compute result/flags.
  always_comb begin
    result  = '0;
    taken   = 1'b0;
    illegal = 1'b0;
    case (alu_op_e'(op))
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: result = a + b;
      OP_XOR: result = a ^ b;
      OP_SUB: result = a - b;
      OP_BEQ: begin
        result = a - b;
        taken  = (a == b);
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_LUI: result = b;
`ifdef BARREL_SHIFT_EN
      OP_SLL: result = a << shamt;
      OP_SRL: result = a >> shamt;
      OP_SRA: result = a_s >>> shamt;
`else
      OP_SLL, OP_SRL, OP_SRA: result = a;
`endif
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: accepts {op, a, b}, runs shifts serially one
// bit per cycle (or in one cycle when BARREL_SHIFT_EN is defined) and holds a
// registered result with zero/taken/illegal flags until the consumer takes it.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_exec_unit_if.slave        bus,
  output state_e                dbg_state
);

  localparam int SW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  alu_op_e          sop_q, sop_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] core_result;
  logic             core_taken;
  logic             core_illegal;
  logic [SW-1:0]    shamt;
  logic             go_serial;
  logic [WIDTH-1:0] acc_shifted;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .op      (bus.in_op),
    .a       (bus.in_a),
    .b       (bus.in_b),
    .result  (core_result),
    .taken   (core_taken),
    .illegal (core_illegal)
  );

  assign shamt = bus.in_b[SW-1:0];

`ifdef BARREL_SHIFT_EN
  assign go_serial = 1'b0;
`else
  assign go_serial = is_shift_op(bus.in_op) && (shamt != '0);
`endif

  // One-bit step of the serial shifter for the captured shift kind.
  always_comb begin
    acc_shifted = acc_q;
    case (sop_q)
      OP_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
      OP_SRA:  acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      default: acc_shifted = acc_q;
    endcase
  end

  // Next-state and next-datapath logic of the IDLE -> (SHIFT|DONE) -> IDLE FSM.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sop_d     = sop_q;
    result_d  = result_q;
    zero_d    = zero_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sop_d = alu_op_e'(bus.in_op);
          if (go_serial) begin
            acc_d   = bus.in_a;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            result_d  = core_result;
            zero_d    = (core_result == '0);
            taken_d   = core_taken;
            illegal_d = core_illegal;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - SW'(1);
        // The last step lands directly in DONE, so shift by n costs 1+n edges.
        if (cnt_q == SW'(1)) begin
          result_d  = acc_shifted;
          zero_d    = (acc_shifted == '0);
          taken_d   = 1'b0;
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sop_q     <= OP_AND;
      result_q  <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sop_q     <= sop_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // Flags are only meaningful while a result is presented.
  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_result  = result_q;
  assign bus.out_zero    = zero_q    && (state_q == DONE);
  assign bus.out_taken   = taken_q   && (state_q == DONE);
  assign bus.out_illegal = illegal_q && (state_q == DONE);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, latency,
// backpressure and mid-shift reset.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic   clk;
  logic   reset;
  state_e dbg_state;
  int     checks;
  int     errors;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BARREL_SHIFT_EN
  localparam int SERIAL = 0;
`else
  localparam int SERIAL = 1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure edges from accept to out_valid, check, then consume.
  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, input logic [31:0] exp_res,
                       input logic exp_z, input logic exp_t, input logic exp_i);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"},  bus.out_result, exp_res);
    check({tag, "_zero"},    32'(bus.out_zero), 32'(exp_z));
    check({tag, "_taken"},   32'(bus.out_taken), 32'(exp_t));
    check({tag, "_illegal"}, 32'(bus.out_illegal), 32'(exp_i));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_state",    32'(dbg_state), 32'(IDLE));
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",   bus.out_result, 32'd0);
    check("rst_flags",    {29'd0, bus.out_zero, bus.out_taken, bus.out_illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Arithmetic and logic
    do_op("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 0, 0, 0);
    do_op("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 32'h0, 1, 0, 0);
    do_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1, 0, 0);
    do_op("and",      4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 0, 0, 0);
    do_op("or",       4'b0001, 32'h0000_0F00, 32'h0000_00F0, 1, 32'h0000_0FF0, 0, 0, 0);
    do_op("xor",      4'b0011, 32'hFFFF_0000, 32'hFF00_FF00, 1, 32'h00FF_FF00, 0, 0, 0);
    do_op("lui",      4'b1010, 32'h1111_1111, 32'hABCD_0000, 1, 32'hABCD_0000, 0, 0, 0);

    // Shifts
    do_op("sra4",     4'b0111, 32'h8000_0000, 32'd4, SERIAL ? 5 : 1, 32'hF800_0000, 0, 0, 0);
    do_op("sll0",     4'b0100, 32'hDEAD_BEEF, 32'd0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    do_op("srl31",    4'b0101, 32'hFFFF_FFFF, 32'd31, SERIAL ? 32 : 1, 32'h1, 0, 0, 0);
    do_op("sll_hib",  4'b0100, 32'h0000_00F0, 32'd36, SERIAL ? 5 : 1, 32'h0000_0F00, 0, 0, 0);

    // Compare, branch, illegal
    do_op("beq_eq",   4'b1000, 32'h1234, 32'h1234, 1, 32'h0, 1, 1, 0);
    do_op("beq_ne",   4'b1000, 32'd5, 32'd3, 1, 32'h2, 0, 0, 0);
    do_op("slt_neg",  4'b1001, 32'hFFFF_FFFF, 32'd1, 1, 32'h1, 0, 0, 0);
    do_op("slt_pos",  4'b1001, 32'd1, 32'hFFFF_FFFF, 1, 32'h0, 1, 0, 0);
    do_op("ill_c",    4'b1100, 32'h1234, 32'h5678, 1, 32'h0, 1, 0, 1);
    do_op("ill_f",    4'b1111, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1, 0, 1);

    // Backpressure: result held for 3 cycles, competing request ignored
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'b0010;
    bus.in_a     = 32'd100;
    bus.in_b     = 32'd23;
    @(posedge clk);
    #1;
    bus.in_op = 4'b0011;
    bus.in_a  = 32'hAAAA_AAAA;
    bus.in_b  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid",  32'(bus.out_valid), 32'd1);
      check("bp_result", bus.out_result, 32'd123);
      check("bp_ready",  32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp_still_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_released_idle", 32'(bus.in_ready), 32'd1);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("bp_no_capture", 32'(seen), 32'd0);

`ifndef BARREL_SHIFT_EN
    // Reset in SHIFT with 10 steps remaining
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 4'b0100;
    bus.in_a     = 32'h1;
    bus.in_b     = 32'd20;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("rs_in_shift", 32'(dbg_state), 32'(SHIFT));
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rs_state",    32'(dbg_state), 32'(IDLE));
    check("rs_in_ready", 32'(bus.in_ready), 32'd1);
    check("rs_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("rs_no_output", 32'(seen), 32'd0);
    check("rs_idle_after", 32'(bus.in_ready), 32'd1);
`endif

    // Unit still works after the aborted op
    do_op("post_add", 4'b0010, 32'd7, 32'd8, 1, 32'd15, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
